// File: rtl/req_arbiter_pkg.sv
// rtl/req_arbiter_pkg.sv - shared types, defaults and highest-set-bit helper for req_arbiter
package req_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int N_REQ_DEF    = 8;
  localparam int MAX_HOLD_DEF = 15;
  localparam int VEC_MAX      = 16;

  // Index of the highest set bit; an all-zero vector yields 0.
  function automatic int hi_index(input logic [VEC_MAX-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < VEC_MAX; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/req_arbiter_prio_enc_n.sv
// rtl/req_arbiter_prio_enc_n.sv - combinational highest-set-bit encoder with any-set flag
module prio_enc_n
  import req_arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [VEC_MAX-1:0] ext;

  always_comb begin
    ext        = '0;
    ext[N-1:0] = vec_i;
  end

  assign idx_o = W'(hi_index(ext));
  assign any_o = |vec_i;

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - N-way request arbiter with hold timeout; REQ_ARBITER_ROUND_ROBIN_EN
// selects round-robin priority instead of fixed highest-index priority.
module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IDX_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               rel_done, rel_drop, rel_limit, release_now;

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
  logic [N_REQ-1:0]   req_masked;
  logic [IDX_W-1:0]   idx_masked, idx_full;
  logic               any_masked;

  // Only indices below the last owner stay eligible in the masked vector.
  always_comb begin
    req_masked = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_masked[i] = req[i] && (i < int'(last_q));
    end
  end

  prio_enc_n #(.N(N_REQ), .W(IDX_W)) u_enc_masked (
    .vec_i (req_masked),
    .idx_o (idx_masked),
    .any_o (any_masked)
  );

  prio_enc_n #(.N(N_REQ), .W(IDX_W)) u_enc_full (
    .vec_i (req),
    .idx_o (idx_full),
    .any_o (win_any)
  );

  assign win_idx = any_masked ? idx_masked : idx_full;
`else
  prio_enc_n #(.N(N_REQ), .W(IDX_W)) u_enc (
    .vec_i (req),
    .idx_o (win_idx),
    .any_o (win_any)
  );
`endif

  assign rel_done    = done;
  assign rel_drop    = !req[idx_q];
  assign rel_limit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign release_now = (state_q == GRANT) && (rel_done || rel_drop || rel_limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = GRANT;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (win_any) begin
        gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        idx_d = win_idx;
      end
    end else if (release_now) begin
      gnt_d     = '0;
      idx_d     = '0;
      last_d    = idx_q;
      timeout_d = rel_limit && !rel_done && !rel_drop;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - directed scoreboard bench for req_arbiter (MAX_HOLD=4 main DUT, MAX_HOLD=0 side DUT)
module tb_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, req0;
  logic       done;
  logic [7:0] gnt, gnt0;
  logic [2:0] gnt_idx, gnt_idx0;
  logic       gnt_valid, gnt_valid0, timeout, timeout0;

  int errors = 0;
  int checks = 0;
  logic [2:0] model_last = 3'd0;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  req_arbiter #(.N_REQ(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  req_arbiter #(.N_REQ(8), .MAX_HOLD(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req0),
    .done      (done),
    .gnt       (gnt0),
    .gnt_idx   (gnt_idx0),
    .gnt_valid (gnt_valid0),
    .timeout   (timeout0)
  );

  function automatic logic [2:0] hi_bit(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] model_win(input logic [7:0] v);
`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    logic [7:0] m;
    m = 8'd0;
    for (int i = 0; i < 8; i++) m[i] = v[i] && (i < int'(model_last));
    return (m != 8'd0) ? hi_bit(m) : hi_bit(v);
`else
    return hi_bit(v);
`endif
  endfunction

  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic v,
                      input logic [2:0] i, input logic t, input string tag);
    exp_t e;
    req  = r;
    done = d;
    e.gnt   = v ? (8'd1 << i) : 8'd0;
    e.idx   = v ? i : 3'd0;
    e.valid = v;
    e.to    = t;
    e.tag   = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(32'(gnt),       32'(e.gnt),   {e.tag, ".gnt"});
    chk(32'(gnt_idx),   32'(e.idx),   {e.tag, ".idx"});
    chk(32'(gnt_valid), 32'(e.valid), {e.tag, ".valid"});
    chk(32'(timeout),   32'(e.to),    {e.tag, ".timeout"});
  endtask

  initial begin
    logic [2:0] w;
    rst_n = 1'b0;
    req0  = 8'd0;

    for (int k = 0; k < 3; k++) step(8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, "reset");
    rst_n = 1'b1;
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "idle");

    // Fixed-priority grant, done release, then next owner.
    step(8'h26, 1'b0, 1'b1, 3'd5, 1'b0, "fix_grant5");
    step(8'h26, 1'b1, 1'b0, 3'd0, 1'b0, "fix_done");
    step(8'h06, 1'b0, 1'b1, 3'd2, 1'b0, "fix_grant2");
    step(8'h06, 1'b1, 1'b0, 3'd0, 1'b0, "fix_done2");
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "idle2");

    // Timeout after exactly four granted cycles, then re-grant.
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "to_hold1");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "to_hold2");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "to_hold3");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "to_hold4");
    step(8'h01, 1'b0, 1'b0, 3'd0, 1'b1, "to_release");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "to_regrant");
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "to_drop");

    // Request drop by owner 7.
    step(8'h80, 1'b0, 1'b1, 3'd7, 1'b0, "drop_grant7");
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "drop_release");

    // done coincides with the hold limit: normal release.
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "co_hold1");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "co_hold2");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "co_hold3");
    step(8'h01, 1'b0, 1'b1, 3'd0, 1'b0, "co_hold4");
    step(8'h01, 1'b1, 1'b0, 3'd0, 1'b0, "co_done_limit");
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "co_idle");

    // MAX_HOLD=0 never times out.
    req0 = 8'h01;
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "nh_start");
    for (int k = 0; k < 30; k++) begin
      step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "nh_main_idle");
      chk(32'(gnt_valid0), 32'd1, "nh_valid");
      chk(32'(timeout0),   32'd0, "nh_timeout");
    end
    req0 = 8'h00;
    step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "nh_stop");
    chk(32'(gnt_valid0), 32'd0, "nh_released");

    // Reset mid-grant drops the grant on the same edge.
    step(8'h80, 1'b0, 1'b1, 3'd7, 1'b0, "rst_grant");
    rst_n = 1'b0;
    step(8'h80, 1'b0, 1'b0, 3'd0, 1'b0, "rst_mid");
    rst_n = 1'b1;
    model_last = 3'd0;

`ifdef REQ_ARBITER_ROUND_ROBIN_EN
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, 1'b1, 3'(7 - (k % 8)), 1'b0, "rr_grant");
      step(8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, "rr_idle");
    end
    model_last = 3'd7;
`endif

    // Sweep every nonzero request pattern from IDLE.
    for (int v = 1; v < 256; v++) begin
      w = model_win(8'(v));
      step(8'(v), 1'b0, 1'b1, w, 1'b0, "sweep");
      chk(32'($onehot(gnt)), 32'd1, "sweep_onehot");
      chk(32'(gnt_valid), 32'(|gnt), "sweep_valid_or");
      step(8'h00, 1'b0, 1'b0, 3'd0, 1'b0, "sweep_rel");
      model_last = w;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
